mul16_shift_add: RTL



---
 rtl/mul16_shift_add.sv | 100 ++++++++++
 1 files changed

// File: rtl/mul16_shift_add.sv
// Iterative unsigned 16x16->32 shift-add multiplier.
// It drives one Adder16bit per step, so the result appears 16 clocks after accept.
module Adder16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] Sum,
  output logic        Co
);
  assign {Co, Sum} = {1'b0, A} + {1'b0, B} + {16'd0, Ci};
endmodule

module mul16_shift_add (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [15:0] add_sum;
  logic        add_co;
  logic [15:0] step_s;
  logic        step_c;

  Adder16bit u_add (
    .A   (hi_q),
    .B   (a_q),
    .Ci  (1'b0),
    .Sum (add_sum),
    .Co  (add_co)
  );

  // The adder carry re-enters at bit 31, so the full-range product stays exact.
  always_comb begin
    step_c = lo_q[0] ? add_co  : 1'b0;
    step_s = lo_q[0] ? add_sum : hi_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          a_d     = in_a;
          hi_d    = 16'd0;
          lo_d    = in_b;
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        {hi_d, lo_d} = {step_c, step_s, lo_q[15:1]};
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      state_q <= IDLE;
      a_q     <= 16'd0;
      hi_q    <= 16'd0;
      lo_q    <= 16'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = {hi_q, lo_q};
endmodule
